// File: rtl/ctrl_pipe_hazard_pkg.sv
// mips_pkg: shared widths, forward-select encodings, the E-stage control
// bundle with its bubble value, and small specifier-match helpers used by
// the pipeline control registers and the hazard unit.
package mips_pkg;

    localparam int ALUC_W = 3;
    localparam int REG_W  = 5;

    // Execute-operand / decode-comparator forward selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Control bits carried by the ID/EX register
    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
        logic              alusrc;
        logic              regdst;
        logic [ALUC_W-1:0] alucontrol;
    } e_ctrl_t;

    // A bubble is an instruction that does nothing: every control bit low
    localparam e_ctrl_t E_BUBBLE = '{
        regwrite:   1'b0,
        memtoreg:   1'b0,
        memwrite:   1'b0,
        alusrc:     1'b0,
        regdst:     1'b0,
        alucontrol: {ALUC_W{1'b0}}
    };

    // True when a source specifier names the destination; r0 never matches
    function automatic logic reg_hit(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dst
    );
        return (src != {REG_W{1'b0}}) && (src == dst);
    endfunction

    // Youngest in-flight producer wins: MEM before WB, else register file
    function automatic logic [1:0] fwd_select(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dst_m,
        input logic             we_m,
        input logic [REG_W-1:0] dst_w,
        input logic             we_w
    );
        logic [1:0] sel;
        if (we_m && reg_hit(src, dst_m)) begin
            sel = FWD_M;
        end else if (we_w && reg_hit(src, dst_w)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_hazard_unit.sv
// hazard_unit: purely combinational load-use / branch-compare stall,
// IF/ID flush and forwarding selects for the 5-stage MIPS-32 pipeline.
// Stall and flush are held low while the pipeline is in reset so that the
// fetch side never sees a spurious hold or flush from undefined stage state.
module hazard_unit
    import mips_pkg::*;
(
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_rsD,
    input  logic [REG_W-1:0] i_rtD,
    input  logic             i_branchD,
    input  logic             i_pcsrcD,
    input  logic             i_jumpD,
    input  logic [REG_W-1:0] i_rsE,
    input  logic [REG_W-1:0] i_rtE,
    input  logic [REG_W-1:0] i_writeregE,
    input  logic             i_regwriteE,
    input  logic             i_memtoregE,
    input  logic [REG_W-1:0] i_writeregM,
    input  logic             i_regwriteM,
    input  logic             i_memtoregM,
    input  logic [REG_W-1:0] i_writeregW,
    input  logic             i_regwriteW,
    output logic             o_stall,
    output logic             o_flushD,
    output logic             o_forwardAD,
    output logic             o_forwardBD,
    output logic [1:0]       o_forwardAE,
    output logic [1:0]       o_forwardBE
);

    logic w_lwstall;
    logic w_branchstall;

    // Stall and flush: a stall always suppresses the branch/jump flush
    always_comb begin
        w_lwstall     = 1'b0;
        w_branchstall = 1'b0;
        o_stall       = 1'b0;
        o_flushD      = 1'b0;
        w_lwstall = i_memtoregE &
                    (reg_hit(i_rsD, i_rtE) | reg_hit(i_rtD, i_rtE));
        w_branchstall = i_branchD &
            ((i_regwriteE & (reg_hit(i_rsD, i_writeregE) | reg_hit(i_rtD, i_writeregE))) |
             (i_memtoregM & (reg_hit(i_rsD, i_writeregM) | reg_hit(i_rtD, i_writeregM))));
        if (i_rst_n) begin
            o_stall  = w_lwstall | w_branchstall;
            o_flushD = (i_pcsrcD | i_jumpD) & ~o_stall;
        end else begin
            o_stall  = 1'b0;
            o_flushD = 1'b0;
        end
    end

    // Forward selects for the decode comparator and the execute operands
    always_comb begin
        o_forwardAD = i_regwriteM & reg_hit(i_rsD, i_writeregM);
        o_forwardBD = i_regwriteM & reg_hit(i_rtD, i_writeregM);
        o_forwardAE = fwd_select(i_rsE, i_writeregM, i_regwriteM, i_writeregW, i_regwriteW);
        o_forwardBE = fwd_select(i_rtE, i_writeregM, i_regwriteM, i_writeregW, i_regwriteW);
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: ID/EX, EX/MEM and MEM/WB control/specifier registers of
// the 5-stage MIPS-32 core plus the hazard unit that stalls, flushes and
// forwards around them. Optional build macro STALL_CNT_EN adds a saturating
// stall-cycle counter on port stall_count (width CNT_W).
module ctrl_pipe_hazard #(
    parameter int ALUC_W = 3,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regwriteD,
    input  logic              memtoregD,
    input  logic              memwriteD,
    input  logic              branchD,
    input  logic              alusrcD,
    input  logic              regdstD,
    input  logic [ALUC_W-1:0] alucontrolD,
    input  logic              pcsrcD,
    input  logic              jumpD,
    input  logic [REG_W-1:0]  rsD,
    input  logic [REG_W-1:0]  rtD,
    input  logic [REG_W-1:0]  rdD,
    output logic              regwriteE,
    output logic              memtoregE,
    output logic              memwriteE,
    output logic              alusrcE,
    output logic              regdstE,
    output logic [ALUC_W-1:0] alucontrolE,
    output logic [REG_W-1:0]  rsE,
    output logic [REG_W-1:0]  rtE,
    output logic [REG_W-1:0]  writeregE,
    output logic              regwriteM,
    output logic              memtoregM,
    output logic              memwriteM,
    output logic [REG_W-1:0]  writeregM,
    output logic              regwriteW,
    output logic              memtoregW,
    output logic [REG_W-1:0]  writeregW,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_count
`endif
);

    import mips_pkg::*;

    e_ctrl_t          w_ctrlD;
    e_ctrl_t          r_ctrlE;
    logic [REG_W-1:0] r_rsE;
    logic [REG_W-1:0] r_rtE;
    logic [REG_W-1:0] r_rdE;
    logic [REG_W-1:0] w_writeregE;
    logic             r_regwriteM;
    logic             r_memtoregM;
    logic             r_memwriteM;
    logic [REG_W-1:0] r_writeregM;
    logic             r_regwriteW;
    logic             r_memtoregW;
    logic [REG_W-1:0] r_writeregW;
    logic             w_stall;

    assign w_ctrlD = '{
        regwrite:   regwriteD,
        memtoreg:   memtoregD,
        memwrite:   memwriteD,
        alusrc:     alusrcD,
        regdst:     regdstD,
        alucontrol: alucontrolD
    };

    assign w_writeregE = r_ctrlE.regdst ? r_rdE : r_rtE;

    // ID/EX register: a stall turns the held decode slot into a bubble here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrlE <= E_BUBBLE;
            r_rsE   <= {REG_W{1'b0}};
            r_rtE   <= {REG_W{1'b0}};
            r_rdE   <= {REG_W{1'b0}};
        end else if (w_stall) begin
            r_ctrlE <= E_BUBBLE;
            r_rsE   <= {REG_W{1'b0}};
            r_rtE   <= {REG_W{1'b0}};
            r_rdE   <= {REG_W{1'b0}};
        end else begin
            r_ctrlE <= w_ctrlD;
            r_rsE   <= rsD;
            r_rtE   <= rtD;
            r_rdE   <= rdD;
        end
    end

    // EX/MEM and MEM/WB registers: always advance, bubbles flow as zeros
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regwriteM <= 1'b0;
            r_memtoregM <= 1'b0;
            r_memwriteM <= 1'b0;
            r_writeregM <= {REG_W{1'b0}};
            r_regwriteW <= 1'b0;
            r_memtoregW <= 1'b0;
            r_writeregW <= {REG_W{1'b0}};
        end else begin
            r_regwriteM <= r_ctrlE.regwrite;
            r_memtoregM <= r_ctrlE.memtoreg;
            r_memwriteM <= r_ctrlE.memwrite;
            r_writeregM <= w_writeregE;
            r_regwriteW <= r_regwriteM;
            r_memtoregW <= r_memtoregM;
            r_writeregW <= r_writeregM;
        end
    end

    hazard_unit u_hazard (
        .i_rst_n     (rst_n),
        .i_rsD       (rsD),
        .i_rtD       (rtD),
        .i_branchD   (branchD),
        .i_pcsrcD    (pcsrcD),
        .i_jumpD     (jumpD),
        .i_rsE       (r_rsE),
        .i_rtE       (r_rtE),
        .i_writeregE (w_writeregE),
        .i_regwriteE (r_ctrlE.regwrite),
        .i_memtoregE (r_ctrlE.memtoreg),
        .i_writeregM (r_writeregM),
        .i_regwriteM (r_regwriteM),
        .i_memtoregM (r_memtoregM),
        .i_writeregW (r_writeregW),
        .i_regwriteW (r_regwriteW),
        .o_stall     (w_stall),
        .o_flushD    (flushD),
        .o_forwardAD (forwardAD),
        .o_forwardBD (forwardBD),
        .o_forwardAE (forwardAE),
        .o_forwardBE (forwardBE)
    );

    assign stallF      = w_stall;
    assign stallD      = w_stall;
    assign regwriteE   = r_ctrlE.regwrite;
    assign memtoregE   = r_ctrlE.memtoreg;
    assign memwriteE   = r_ctrlE.memwrite;
    assign alusrcE     = r_ctrlE.alusrc;
    assign regdstE     = r_ctrlE.regdst;
    assign alucontrolE = r_ctrlE.alucontrol;
    assign rsE         = r_rsE;
    assign rtE         = r_rtE;
    assign writeregE   = w_writeregE;
    assign regwriteM   = r_regwriteM;
    assign memtoregM   = r_memtoregM;
    assign memwriteM   = r_memwriteM;
    assign writeregM   = r_writeregM;
    assign regwriteW   = r_regwriteW;
    assign memtoregW   = r_memtoregW;
    assign writeregW   = r_writeregW;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_count;

    // Saturating count of stalled cycles; holds at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
